// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction-fetch sequencer between a 64x32 registered ROM
// and the decode stage. Owns the PC, issues one ROM read per cycle when buffer
// credit allows, captures the returning word one cycle later into a 2-entry
// FIFO, and presents the FIFO head to decode.
//
// Handshake: id_valid is high whenever the FIFO holds a word; the head
// (id_inst/id_pc) is held stable until the cycle where id_valid && id_ready,
// in which decode takes it. A redirect clears the FIFO and any in-flight read;
// a word accepted in the same cycle as a redirect is still consumed.
//
// Optional feature macro: FETCH_END_HALT_EN -- when defined, fetch stops once
// the PC reaches 0x100 (end of ROM) and reports fetch_halt after draining.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [5:0]  Inst_addr,
  input  logic [31:0] Inst_code,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        fetch_halt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
`ifdef FETCH_END_HALT_EN
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [31:0] END_PC = 32'h0000_0100;
`endif

  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] buf_inst [2];
  logic [31:0] buf_pc   [2];
  logic        head;
  logic [1:0]  count;
  logic [0:0]  state;

  logic        pop;
  logic        push;
  logic        at_end;
  logic        issue;
  logic [2:0]  occupancy;
  logic        wr_idx;

  // Handshake and credit: a read may only be issued if its word has a slot
  // when it returns, counting both buffered and in-flight words.
  always_comb begin
    pop       = id_valid && id_ready;
    push      = inflight;
    occupancy = {1'b0, count} + {2'b00, inflight};
    wr_idx    = head ^ count[0];
`ifdef FETCH_END_HALT_EN
    at_end    = (fetch_pc >= END_PC);
`else
    at_end    = 1'b0;
`endif
    issue     = (state == ST_RUN) && !redirect && !at_end &&
                ((occupancy <= 3'd1) || pop);
  end

  // PC, in-flight tracking and run/halt state; redirect beats everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      state       <= ST_RUN;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc & ~32'h3;
      inflight    <= 1'b0;
      state       <= ST_RUN;
    end else begin
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else begin
        inflight    <= 1'b0;
      end
`ifdef FETCH_END_HALT_EN
      if (state == ST_RUN && at_end) begin
        state <= ST_HALT;
      end
`endif
    end
  end

  // Two-entry FIFO: capture the returning ROM word, advance head on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_inst[i] <= 32'h0;
        buf_pc[i]   <= 32'h0;
      end
    end else if (redirect) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        buf_inst[wr_idx] <= Inst_code;
        buf_pc[wr_idx]   <= inflight_pc;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Output view of the FIFO head and the ROM address.
  always_comb begin
    Inst_addr = fetch_pc[7:2];
    id_valid  = (count != 2'd0);
    id_inst   = buf_inst[head];
    id_pc     = buf_pc[head];
`ifdef FETCH_END_HALT_EN
    fetch_halt = (state == ST_HALT) && (count == 2'd0) && !inflight;
`else
    fetch_halt = 1'b0;
`endif
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: registered ROM model, program-order reference
// model feeding an expected queue, decoupled accept monitor, directed timing
// scenarios and a randomized ready/redirect phase.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  Inst_addr;
  logic [31:0] Inst_code;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        fetch_halt;

`ifdef FETCH_END_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int n_checks  = 0;
  int n_errors  = 0;
  int n_accepts = 0;

  logic [31:0] rom [64];
  logic [63:0] exp_q[$];
  logic [31:0] next_pc;

  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_inst;
  logic [5:0]  s_addr;
  logic        s_halt;

  inst_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .Inst_addr   (Inst_addr),
    .Inst_code   (Inst_code),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .fetch_halt  (fetch_halt)
  );

  // clock / reset / ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) Inst_code <= rom[Inst_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the program-order stream of {inst, pc} decode must see.
  task automatic refill();
    while (exp_q.size() < 8 && !(HALT_EN && next_pc >= 32'h100)) begin
      exp_q.push_back({rom[next_pc[7:2]], next_pc});
      next_pc = next_pc + 32'd4;
    end
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, update model.
  task automatic tick(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst = r; redirect = rd; redirect_pc = rpc; id_ready = rdy;
    refill();
    @(negedge clk);
    s_valid = id_valid; s_pc = id_pc; s_inst = id_inst;
    s_addr = Inst_addr; s_halt = fetch_halt;
    @(posedge clk);
    if (r) begin
      exp_q.delete(); next_pc = 32'h0;
    end else if (rd) begin
      exp_q.delete(); next_pc = rpc & ~32'h3;
    end
    #1;
  endtask

  // Monitor: every accepted word must be the next one in program order.
  always @(negedge clk) begin
    if (rst === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
      logic [63:0] e;
      n_checks++;
      n_accepts++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL accept_unexpected: got pc %h expected no word", id_pc);
      end else begin
        e = exp_q.pop_front();
        if ({id_inst, id_pc} !== e) begin
          n_errors++;
          $display("FAIL accept_order: got pc %h inst %h expected pc %h inst %h",
                   id_pc, id_inst, e[31:0], e[63:32]);
        end
      end
    end
  end

  // Cycles 0..2 after reset release with ready high.
  task automatic check_restart(input string tag);
    tick(0, 0, 0, 1);
    chk({tag, "_c0_valid"}, {31'h0, s_valid}, 32'h0);
    chk({tag, "_c0_addr"}, {26'h0, s_addr}, 32'h0);
    tick(0, 0, 0, 1);
    chk({tag, "_c1_valid"}, {31'h0, s_valid}, 32'h0);
    tick(0, 0, 0, 1);
    chk({tag, "_c2_valid"}, {31'h0, s_valid}, 32'h1);
    chk({tag, "_c2_pc"}, s_pc, 32'h0);
    chk({tag, "_c2_inst"}, s_inst, rom[0]);
  endtask

  // Redirect issued in this cycle; checks R+1..R+3 with ready high.
  task automatic check_redirect(input string tag, input logic [31:0] tgt, input logic rdy);
    logic [31:0] a;
    a = tgt & ~32'h3;
    tick(0, 1, tgt, rdy);
    tick(0, 0, 0, 1);
    chk({tag, "_r1_valid"}, {31'h0, s_valid}, 32'h0);
    tick(0, 0, 0, 1);
    chk({tag, "_r2_valid"}, {31'h0, s_valid}, 32'h0);
    tick(0, 0, 0, 1);
    chk({tag, "_r3_valid"}, {31'h0, s_valid}, 32'h1);
    chk({tag, "_r3_pc"}, s_pc, a);
    chk({tag, "_r3_inst"}, s_inst, rom[a[7:2]]);
  endtask

  initial begin
    logic [31:0] h_pc, h_inst;
    logic [5:0]  h_addr;
    int acc0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    next_pc = 32'h0;
    @(posedge clk); #1;

    // reset state
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 1);
    chk("reset_valid", {31'h0, s_valid}, 32'h0);
    chk("reset_pc", s_pc, 32'h0);
    chk("reset_inst", s_inst, 32'h0);
    chk("reset_addr", {26'h0, s_addr}, 32'h0);
    chk("reset_halt", {31'h0, s_halt}, 32'h0);

    // first fetch and steady stream
    check_restart("start");
    for (int k = 3; k <= 5; k++) begin
      tick(0, 0, 0, 1);
      chk("stream_valid", {31'h0, s_valid}, 32'h1);
      chk("stream_pc", s_pc, 32'(4 * (k - 2)));
    end

    // stall with head at 0x10
    h_addr = 6'h0;
    for (int k = 6; k <= 10; k++) begin
      tick(0, 0, 0, 0);
      chk("stall_valid", {31'h0, s_valid}, 32'h1);
      chk("stall_pc", s_pc, 32'h10);
      chk("stall_inst", s_inst, rom[4]);
      if (k == 6) h_addr = s_addr;
      else chk("stall_addr_frozen", {26'h0, s_addr}, {26'h0, h_addr});
    end
    for (int k = 11; k <= 16; k++) begin
      tick(0, 0, 0, 1);
      chk("release_valid", {31'h0, s_valid}, 32'h1);
      chk("release_pc", s_pc, 32'h10 + 32'(4 * (k - 11)));
    end

    // redirect with FIFO full and decode stalled
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    check_redirect("redir_full", 32'h43, 1'b0);

    // redirect in the same cycle as an accept
    tick(0, 0, 0, 1);
    h_pc = {24'h0, 8'($urandom_range(0, 60) * 4)};
    check_redirect("redir_pop", h_pc, 1'b1);

    // run past the end of the ROM
    tick(0, 1, 32'hF0, 1);
    for (int j = 1; j <= 8; j++) begin
      tick(0, 0, 0, 1);
      if (j == 3) chk("end_pc_f0", s_pc, 32'hF0);
      if (j == 6) chk("end_pc_fc", s_pc, 32'hFC);
`ifdef FETCH_END_HALT_EN
      if (j == 7) chk("halt_valid", {31'h0, s_valid}, 32'h0);
      if (j == 8) chk("halt_flag", {31'h0, s_halt}, 32'h1);
`else
      if (j == 4) chk("wrap_addr_63", {26'h0, s_addr}, 32'd63);
      if (j == 5) chk("wrap_addr_0", {26'h0, s_addr}, 32'd0);
      if (j == 7) chk("wrap_pc", s_pc, 32'h100);
      if (j == 7) chk("wrap_inst", s_inst, rom[0]);
      if (j == 8) chk("wrap_halt", {31'h0, s_halt}, 32'h0);
`endif
    end
`ifdef FETCH_END_HALT_EN
    tick(0, 1, 32'h0, 1);
    tick(0, 0, 0, 1);
    chk("unhalt_flag", {31'h0, s_halt}, 32'h0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("unhalt_pc", s_pc, 32'h0);
`endif

    // reset mid-stream with FIFO full
    tick(0, 1, 32'h20, 1);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check_restart("midrst");

    // randomized ready and redirects
    acc0 = n_accepts;
    for (int k = 0; k < 400; k++) begin
      logic rd;
      logic [31:0] tgt;
      rd = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom() : {24'h0, 8'($urandom_range(0, 255))};
      tick(0, rd, tgt, ($urandom_range(0, 3) != 0));
    end
    chk("random_progress", {31'h0, (n_accepts - acc0) > 50}, 32'h1);

    // stalled drain: decode idle must not change head
    tick(0, 1, 32'h0, 1);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0);
    h_pc = s_pc; h_inst = s_inst;
    tick(0, 0, 0, 0);
    chk("idle_pc_stable", s_pc, h_pc);
    chk("idle_inst_stable", s_inst, h_inst);
    tick(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
